dual_issue_dispatcher: RTL and testbench

//  Distributes a single in-order instruction stream across the two issue lanes of the

---
 rtl/dispatch_pkg.sv | 15 +
 rtl/dispatch_lane_fifo.sv | 65 ++++++
 rtl/dual_issue_dispatcher.sv | 96 +++++++++
 tb/tb_dual_issue_dispatcher.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared widths, lane indices and the buffered entry layout for the dual-issue dispatcher.
package dispatch_pkg;

    localparam int DISPATCH_INSTR_W = 32;
    localparam int DISPATCH_SEQ_W   = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef struct packed {
        logic [DISPATCH_SEQ_W-1:0]   seq;
        logic [DISPATCH_INSTR_W-1:0] instr;
    } dispatch_entry_t;

endpackage

// File: rtl/dispatch_lane_fifo.sv
// First-word fall-through lane buffer: head is visible while non-empty, zero when empty.
module dispatch_lane_fifo
    import dispatch_pkg::*;
#(
    parameter int WIDTH = $bits(dispatch_entry_t),
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign w_pop   = i_pop && o_valid;

    // NOTE: storage has no reset; the pointers and count alone define what is valid,
    // so leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dual_issue_dispatcher.sv
// Round-robin dispatch of one in-order stream into two lane buffers, skipping a full lane
// and tagging each accepted instruction with a wrapping sequence number.
module dual_issue_dispatcher
    import dispatch_pkg::*;
#(
    parameter int INSTR_W = DISPATCH_INSTR_W,
    parameter int DEPTH   = 4,
    parameter int SEQ_W   = DISPATCH_SEQ_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     instr_valid,
    input  logic [INSTR_W-1:0]       instr,
    output logic                     instr_ready,
    output logic                     lane0_valid,
    output logic [INSTR_W-1:0]       lane0_instr,
    output logic [SEQ_W-1:0]         lane0_seq,
    input  logic                     lane0_ready,
    output logic                     lane1_valid,
    output logic [INSTR_W-1:0]       lane1_instr,
    output logic [SEQ_W-1:0]         lane1_seq,
    input  logic                     lane1_ready,
    output logic [$clog2(DEPTH):0]   lane0_count,
    output logic [$clog2(DEPTH):0]   lane1_count
);

    typedef struct packed {
        logic [SEQ_W-1:0]   seq;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic             r_rr_sel;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic             w_full0, w_full1;
    logic             w_accept;
    logic             w_target;
    entry_t           w_push_entry, w_head0, w_head1;

    // Fullness is taken from registered counts only; same-cycle pops do not open a slot.
    assign instr_ready  = resetn && !flush && (!w_full0 || !w_full1);
    assign w_accept     = instr_valid && instr_ready;
    assign w_push_entry = '{seq: r_seq_cnt, instr: instr};

    // NOTE: w_target gets its default before the conditional overrides, so no latch is inferred.
    always_comb begin
        w_target = r_rr_sel;
        if (r_rr_sel == LANE0 && w_full0)      w_target = LANE1;
        else if (r_rr_sel == LANE1 && w_full1) w_target = LANE0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_sel  <= LANE0;
            r_seq_cnt <= '0;
        end else if (flush) begin
            r_rr_sel  <= LANE0;
            r_seq_cnt <= '0;
        end else if (w_accept) begin
            r_rr_sel  <= ~w_target;
            r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
        end
    end

    dispatch_lane_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_lane0 (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (flush),
        .i_push      (w_accept && (w_target == LANE0)),
        .i_push_data (w_push_entry),
        .i_pop       (lane0_ready),
        .o_valid     (lane0_valid),
        .o_data      (w_head0),
        .o_count     (lane0_count),
        .o_full      (w_full0)
    );

    dispatch_lane_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_lane1 (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (flush),
        .i_push      (w_accept && (w_target == LANE1)),
        .i_push_data (w_push_entry),
        .i_pop       (lane1_ready),
        .o_valid     (lane1_valid),
        .o_data      (w_head1),
        .o_count     (lane1_count),
        .o_full      (w_full1)
    );

    assign lane0_instr = w_head0.instr;
    assign lane0_seq   = w_head0.seq;
    assign lane1_instr = w_head1.instr;
    assign lane1_seq   = w_head1.seq;

endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_dual_issue_dispatcher;

    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int SEQ_W   = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic               flush;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               lane0_valid, lane1_valid;
    logic [INSTR_W-1:0] lane0_instr, lane1_instr;
    logic [SEQ_W-1:0]   lane0_seq, lane1_seq;
    logic               lane0_ready, lane1_ready;
    logic [CW-1:0]      lane0_count, lane1_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each lane is a queue of {seq, instr}; round-robin pointer and tag as integers.
    logic [SEQ_W+INSTR_W-1:0] q0[$];
    logic [SEQ_W+INSTR_W-1:0] q1[$];
    int m_rr  = 0;
    int m_seq = 0;

    dual_issue_dispatcher #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .lane0_valid (lane0_valid),
        .lane0_instr (lane0_instr),
        .lane0_seq   (lane0_seq),
        .lane0_ready (lane0_ready),
        .lane1_valid (lane1_valid),
        .lane1_instr (lane1_instr),
        .lane1_seq   (lane1_seq),
        .lane1_ready (lane1_ready),
        .lane0_count (lane0_count),
        .lane1_count (lane1_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_rr  = 0;
        m_seq = 0;
    endtask

    function automatic logic model_ready();
        return !flush && (q0.size() < DEPTH || q1.size() < DEPTH);
    endfunction

    task automatic compare_outputs();
        check("instr_ready", 64'(instr_ready), 64'(model_ready()));
        check("lane0_valid", 64'(lane0_valid), 64'(q0.size() != 0));
        check("lane1_valid", 64'(lane1_valid), 64'(q1.size() != 0));
        check("lane0_count", 64'(lane0_count), 64'(q0.size()));
        check("lane1_count", 64'(lane1_count), 64'(q1.size()));
        check("lane0_head", {28'(0), lane0_seq, lane0_instr}, (q0.size() != 0) ? 64'(q0[0]) : 64'(0));
        check("lane1_head", {28'(0), lane1_seq, lane1_instr}, (q1.size() != 0) ? 64'(q1[0]) : 64'(0));
    endtask

    task automatic model_update();
        logic acc;
        int   tgt;
        if (flush) begin
            model_clear();
            return;
        end
        acc = instr_valid && model_ready();
        tgt = m_rr;
        if (tgt == 0 && q0.size() == DEPTH) tgt = 1;
        else if (tgt == 1 && q1.size() == DEPTH) tgt = 0;
        if (lane0_ready && q0.size() != 0) void'(q0.pop_front());
        if (lane1_ready && q1.size() != 0) void'(q1.pop_front());
        if (acc) begin
            if (tgt == 0) q0.push_back({SEQ_W'(m_seq), instr});
            else          q1.push_back({SEQ_W'(m_seq), instr});
            m_rr  = 1 - tgt;
            m_seq = (m_seq + 1) % (1 << SEQ_W);
        end
    endtask

    task automatic step(input logic v, input logic [INSTR_W-1:0] ins,
                        input logic r0, input logic r1, input logic fl);
        @(negedge clk);
        instr_valid = v;
        instr       = ins;
        lane0_ready = r0;
        lane1_ready = r1;
        flush       = fl;
        #1;
        compare_outputs();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        lane0_ready = 1'b0;
        lane1_ready = 1'b0;
        #3;
        check("rst_ready", 64'(instr_ready), 64'(0));
        check("rst_valid0", 64'(lane0_valid), 64'(0));
        check("rst_valid1", 64'(lane1_valid), 64'(0));
        check("rst_head0", 64'(lane0_instr), 64'(0));
        check("rst_count1", 64'(lane1_count), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        model_clear();

        // Alternation with no pops.
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("alt_count0", 64'(lane0_count), 64'(3));
        check("alt_count1", 64'(lane1_count), 64'(3));
        check("alt_head1_seq", 64'(lane1_seq), 64'(1));

        // Asynchronous reset with entries buffered.
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        instr_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_valid0", 64'(lane0_valid), 64'(0));
        check("midrst_valid1", 64'(lane1_valid), 64'(0));
        check("midrst_count0", 64'(lane0_count), 64'(0));
        check("midrst_ready", 64'(instr_ready), 64'(0));
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
        #1;
        check("postrst_lane0_instr", 64'(lane0_instr), 64'(32'hC0));
        check("postrst_lane0_seq", 64'(lane0_seq), 64'(0));
        check("postrst_lane1_valid", 64'(lane1_valid), 64'(0));

        // Skip a full lane: lane0 never drains, lane1 drains every cycle.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b1, 1'b0);
        #1;
        check("skip_count0", 64'(lane0_count), 64'(DEPTH));

        // Both lanes full, then one lane0 pop.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0);
        #1;
        check("full_ready", 64'(instr_ready), 64'(0));
        step(1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hEF, 1'b0, 1'b0, 1'b0);
        #1;
        check("refill_count0", 64'(lane0_count), 64'(DEPTH));

        // Sequence wrap with both lanes draining (push+pop on the same lane).
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 32'hF00 + 32'(i), 1'b1, 1'b1, 1'b0);

        // Flush with traffic present.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1FF, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        #1;
        check("postflush_seq", 64'(lane0_seq), 64'(0));
        check("postflush_instr", 64'(lane0_instr), 64'(32'h200));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
